// File: rtl/icache_pkg.sv
// icache_pkg: shared constants for the instruction cache.
//   - ICACHE_INDEX_BITS / ICACHE_OFFSET_BITS : default geometry (16 lines x 4 words)
//   - ICACHE_ADDR_W / ICACHE_INST_W          : address and instruction widths
//   - icache_state_e                         : controller state encoding
package icache_pkg;

  localparam int ICACHE_INDEX_BITS  = 4;
  localparam int ICACHE_OFFSET_BITS = 2;
  localparam int ICACHE_ADDR_W      = 32;
  localparam int ICACHE_INST_W      = 32;

  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-controller-side signals of the icache.
//   slave  : the cache's view (takes fetch requests, issues word refills)
//   master : the environment's view (fetch unit + memory controller)
//
// Handshake: a requester raises its enable (if_en / memc_en) with a stable
// address and holds both until the responder pulses its done (if_done /
// memc_done) for exactly one cycle; the data is valid only in that cycle.
interface icache_if;
  import icache_pkg::*;

  logic                     if_en;
  logic [ICACHE_ADDR_W-1:0] if_pc;
  logic                     if_done;
  logic [ICACHE_INST_W-1:0] if_inst;
  logic                     memc_en;
  logic [ICACHE_ADDR_W-1:0] memc_pc;
  logic                     memc_done;
  logic [ICACHE_INST_W-1:0] memc_data;

  modport slave (
    input  if_en, if_pc, memc_done, memc_data,
    output if_done, if_inst, memc_en, memc_pc
  );

  modport master (
    output if_en, if_pc, memc_done, memc_data,
    input  if_done, if_inst, memc_en, memc_pc
  );

endinterface

// File: rtl/icache_line_mem.sv
// icache_line_mem: tag, valid and data storage of the direct-mapped icache.
//   rd_index/rd_word -> rd_valid, rd_tag, rd_data : combinational read
//   wr_index          : line addressed by every write-side operation
//   clr_valid         : clear the valid bit of wr_index
//   wr_en/wr_word/wr_data : write one data word of wr_index
//   fill_en/fill_tag  : set valid and store the tag of wr_index
// Only the valid bits are reset; tag and data are plain memory.
module icache_line_mem
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int TAG_W       = ICACHE_ADDR_W - 2 - OFFSET_BITS - INDEX_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_BITS-1:0]    rd_index,
  input  logic [OFFSET_BITS-1:0]   rd_word,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [ICACHE_INST_W-1:0] rd_data,
  input  logic [INDEX_BITS-1:0]    wr_index,
  input  logic                     clr_valid,
  input  logic                     wr_en,
  input  logic [OFFSET_BITS-1:0]   wr_word,
  input  logic [ICACHE_INST_W-1:0] wr_data,
  input  logic                     fill_en,
  input  logic [TAG_W-1:0]         fill_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]         valid_q, valid_d;
  logic [TAG_W-1:0]         tag_mem  [LINES];
  logic [ICACHE_INST_W-1:0] data_mem [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_word];

  always_comb begin
    valid_d = valid_q;
    if (clr_valid) valid_d[wr_index] = 1'b0;
    if (fill_en)   valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)   data_mem[wr_index][wr_word] <= wr_data;
    if (fill_en) tag_mem[wr_index]           <= fill_tag;
  end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
//   clk, rst      : clock, asynchronous active-high reset
//   rdy           : global stall; when low nothing changes
//   rollback      : pipeline flush; aborts a lookup or refill in progress
//   bus (slave)   : fetch request/response and memory-controller word refill
//   dbg_state     : current controller state
//   hit_cnt/miss_cnt : saturating lookup counters, only when ICACHE_PERF_CNT_EN
//                      is defined
// Hits answer one cycle after the request. A miss invalidates the target line,
// fetches all of its words in order and then answers with the requested word.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  icache_if.slave       bus,
  output icache_state_e dbg_state
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int LINE_LSB = 2 + OFFSET_BITS;
  localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;
  localparam int TAG_W    = ICACHE_ADDR_W - TAG_LSB;
  localparam int LINE_W   = ICACHE_ADDR_W - LINE_LSB;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

  icache_state_e            state_q, state_d;
  logic [OFFSET_BITS-1:0]   k_q, k_d;
  logic [LINE_W-1:0]        line_q, line_d;      // tag+index of the line being refilled
  logic [OFFSET_BITS-1:0]   word_q, word_d;      // word the stalled fetch asked for
  logic [ICACHE_INST_W-1:0] req_inst_q, req_inst_d;
  logic                     if_done_q, if_done_d;
  logic [ICACHE_INST_W-1:0] if_inst_q, if_inst_d;
  logic                     memc_en_q, memc_en_d;
  logic [ICACHE_ADDR_W-1:0] memc_pc_q, memc_pc_d;

  logic [INDEX_BITS-1:0]    req_index, fill_index, mem_index;
  logic [OFFSET_BITS-1:0]   req_word, k_inc;
  logic [TAG_W-1:0]         req_tag, fill_tag, rd_tag;
  logic                     rd_valid, hit;
  logic [ICACHE_INST_W-1:0] rd_data;
  logic                     clr_valid, wr_en, fill_en;
  logic                     unused_pc_bits;

  assign req_index  = bus.if_pc[TAG_LSB-1:LINE_LSB];
  assign req_word   = bus.if_pc[LINE_LSB-1:2];
  assign req_tag    = bus.if_pc[ICACHE_ADDR_W-1:TAG_LSB];
  assign fill_index = line_q[INDEX_BITS-1:0];
  assign fill_tag   = line_q[LINE_W-1:INDEX_BITS];
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign k_inc      = k_q + OFFSET_BITS'(1);
  assign unused_pc_bits = ^bus.if_pc[1:0];

  // Writes only happen at refill start (clear, IDLE) or during REFILL.
  assign mem_index = (state_q == ICACHE_IDLE) ? req_index : fill_index;

  icache_line_mem #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_W      (TAG_W)
  ) u_line_mem (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_word  (req_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_index (mem_index),
    .clr_valid(clr_valid),
    .wr_en    (wr_en),
    .wr_word  (k_q),
    .wr_data  (bus.memc_data),
    .fill_en  (fill_en),
    .fill_tag (fill_tag)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    line_d     = line_q;
    word_d     = word_q;
    req_inst_d = req_inst_q;
    if_done_d  = if_done_q;
    if_inst_d  = if_inst_q;
    memc_en_d  = memc_en_q;
    memc_pc_d  = memc_pc_q;
    clr_valid  = 1'b0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    if (rdy) begin
      if_done_d = 1'b0;
      if (rollback) begin
        // The refilling line was invalidated at refill start, so dropping
        // out here leaves no partially filled line visible.
        state_d   = ICACHE_IDLE;
        memc_en_d = 1'b0;
        k_d       = '0;
      end else begin
        case (state_q)
          ICACHE_IDLE: begin
            // In the if_done cycle if_en still shows the answered request.
            if (bus.if_en && !if_done_q) begin
              if (hit) begin
                if_done_d = 1'b1;
                if_inst_d = rd_data;
              end else begin
                line_d    = bus.if_pc[ICACHE_ADDR_W-1:LINE_LSB];
                word_d    = req_word;
                k_d       = '0;
                clr_valid = 1'b1;
                memc_en_d = 1'b1;
                memc_pc_d = {bus.if_pc[ICACHE_ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                state_d   = ICACHE_REFILL;
              end
            end
          end
          ICACHE_REFILL: begin
            if (bus.memc_done) begin
              wr_en = 1'b1;
              if (k_q == word_q) req_inst_d = bus.memc_data;
              if (k_q == LAST_WORD) begin
                fill_en   = 1'b1;
                memc_en_d = 1'b0;
                if_done_d = 1'b1;
                if_inst_d = (k_q == word_q) ? bus.memc_data : req_inst_q;
                k_d       = '0;
                state_d   = ICACHE_IDLE;
              end else begin
                k_d       = k_inc;
                memc_pc_d = {line_q, k_inc, 2'b00};
              end
            end
          end
          default: state_d = ICACHE_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ICACHE_IDLE;
      k_q        <= '0;
      line_q     <= '0;
      word_q     <= '0;
      req_inst_q <= '0;
      if_done_q  <= 1'b0;
      if_inst_q  <= '0;
      memc_en_q  <= 1'b0;
      memc_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      line_q     <= line_d;
      word_q     <= word_d;
      req_inst_q <= req_inst_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      memc_en_q  <= memc_en_d;
      memc_pc_q  <= memc_pc_d;
    end
  end

  assign bus.if_done = if_done_q;
  assign bus.if_inst = if_inst_q;
  assign bus.memc_en = memc_en_q;
  assign bus.memc_pc = memc_pc_q;
  assign dbg_state   = state_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        lookup;

  // Same acceptance condition as the IDLE branch above.
  assign lookup = rdy && !rollback && (state_q == ICACHE_IDLE) &&
                  bus.if_en && !if_done_q;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed + randomized bench for icache (default geometry:
// 16 lines x 4 words). The reference model tracks which line tags are
// resident and computes hit/miss, refill address order, answer word and
// answer cycle from plain address arithmetic. Memory contents come from a
// sparse table with a hash fallback.
module tb_icache;
  import icache_pkg::*;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;
  icache_state_e dbg_state;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_if bus ();

  icache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus),
    .dbg_state(dbg_state)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  int          m_hit  = 0;
  int          m_miss = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One fetch from request to answer (or abort).
  //   rb_after    >0 : rollback in the cycle after that many refill words
  //   rb_last        : rollback together with the last refill word
  //   stall_after >=0: hold rdy low 5 cycles while presenting that word
  task automatic fetch(input logic [31:0] pc, input int rb_after,
                       input bit rb_last, input int stall_after);
    logic [31:0] exp_inst, stall_pc;
    bit exp_hit, finished, rb_wait, stalled, accept_now;
    int words, lat, cyc, exp_done_cyc, idx, stall_left;
    idx      = int'((pc >> 4) % 16);
    exp_hit  = m_valid[idx] && (m_tag[idx] == pc[31:8]);
    exp_inst = mem_rd(pc & ~32'h3);
    exp_q.delete();
    if (!exp_hit)
      for (int k = 0; k < WORDS; k++) exp_q.push_back((pc & ~32'hF) + 32'(4 * k));
    if (exp_hit) m_hit++;
    else begin
      m_miss++;
      m_valid[idx] = 1'b0;
    end
    @(negedge clk);
    bus.if_en     = 1'b1;
    bus.if_pc     = pc | 32'($urandom_range(0, 3));
    bus.memc_done = 1'b0;
    rollback      = 1'b0;
    rdy           = 1'b1;
    words = 0; cyc = 0; finished = 0; rb_wait = 0; stalled = 0; stall_left = 0;
    stall_pc = '0;
    exp_done_cyc = exp_hit ? 1 : 0;
    lat = $urandom_range(0, 2);
    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      accept_now = 1'b0;
      if (stall_left > 0) begin
        check("stall_memc_pc", bus.memc_pc, stall_pc);
        check("stall_memc_en", {31'b0, bus.memc_en}, 32'd1);
        check("stall_if_done", {31'b0, bus.if_done}, 32'd0);
        stall_left--;
        if (stall_left == 0) begin
          rdy = 1'b1;
          accept_now = 1'b1;
        end
      end else if (rb_wait) begin
        rollback      = 1'b0;
        bus.memc_done = 1'b0;
        check("rb_memc_en", {31'b0, bus.memc_en}, 32'd0);
        check("rb_if_done", {31'b0, bus.if_done}, 32'd0);
        check("rb_state", 32'(dbg_state), 32'(ICACHE_IDLE));
        repeat (3) begin
          @(negedge clk);
          check("rb_quiet", {31'b0, bus.if_done | bus.memc_en}, 32'd0);
        end
        finished = 1'b1;
      end else if (bus.if_done) begin
        bus.memc_done = 1'b0;
        check("if_inst", bus.if_inst, exp_inst);
        check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        check("memc_en_at_done", {31'b0, bus.memc_en}, 32'd0);
        if (!exp_hit) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = pc[31:8];
        end
        finished = 1'b1;
        // if_en stays high through the pulse cycle, as a fetch unit would.
        @(negedge clk);
        check("done_pulse", {31'b0, bus.if_done}, 32'd0);
        check("no_rerequest", {31'b0, bus.memc_en}, 32'd0);
        bus.if_en = 1'b0;
      end else if (exp_done_cyc > 0 && cyc >= exp_done_cyc) begin
        check("if_done_missing", {31'b0, bus.if_done}, 32'd1);
        finished = 1'b1;
      end else if (bus.memc_en && exp_hit) begin
        check("memc_en_on_hit", {31'b0, bus.memc_en}, 32'd0);
        finished = 1'b1;
      end else begin
        bus.memc_done = 1'b0;
        bus.memc_data = $urandom;
        if (bus.memc_en && words < WORDS && exp_q.size() > 0) begin
          if (rb_after > 0 && words == rb_after) begin
            rollback  = 1'b1;
            bus.if_en = 1'b0;
            rb_wait   = 1'b1;
          end else if (lat > 0) begin
            lat--;
          end else if (words == stall_after && !stalled) begin
            stalled       = 1'b1;
            rdy           = 1'b0;
            stall_left    = 5;
            stall_pc      = exp_q[0];
            bus.memc_done = 1'b1;
            bus.memc_data = mem_rd(exp_q[0]);
          end else begin
            bus.memc_done = 1'b1;
            bus.memc_data = mem_rd(exp_q[0]);
            accept_now    = 1'b1;
          end
        end
      end
      if (accept_now) begin
        check("memc_pc", bus.memc_pc, exp_q.pop_front());
        words++;
        lat = $urandom_range(0, 2);
        if (words == WORDS) begin
          if (rb_last) begin
            rollback  = 1'b1;
            bus.if_en = 1'b0;
            rb_wait   = 1'b1;
          end else begin
            exp_done_cyc = cyc + 1;
          end
        end
      end
    end
    check("fetch_finished", {31'b0, finished}, 32'd1);
    bus.if_en     = 1'b0;
    bus.memc_done = 1'b0;
    rollback      = 1'b0;
    rdy           = 1'b1;
  endtask

  // Request raised in the same cycle as a rollback: must be ignored.
  task automatic lookup_rollback(input logic [31:0] pc);
    @(negedge clk);
    bus.if_en = 1'b1;
    bus.if_pc = pc;
    rollback  = 1'b1;
    @(negedge clk);
    bus.if_en = 1'b0;
    rollback  = 1'b0;
    check("rbl_if_done", {31'b0, bus.if_done}, 32'd0);
    check("rbl_memc_en", {31'b0, bus.memc_en}, 32'd0);
    @(negedge clk);
    check("rbl_quiet", {31'b0, bus.if_done | bus.memc_en}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = '0; bus.memc_done = 1'b0; bus.memc_data = '0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    mem[32'h100] = 32'hA0;
    mem[32'h104] = 32'hA1;
    mem[32'h108] = 32'hA2;
    mem[32'h10C] = 32'hA3;
    repeat (3) @(negedge clk);
    check("rst_if_done", {31'b0, bus.if_done}, 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_memc_en", {31'b0, bus.memc_en}, 32'd0);
    check("rst_memc_pc", bus.memc_pc, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ICACHE_IDLE));
    rst = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // Cold miss, then hits on the fresh line, then a rollback-aborted lookup.
    fetch(32'h0000_0104, 0, 1'b0, -1);
    fetch(32'h0000_0108, 0, 1'b0, -1);
    fetch(32'h0000_010C, 0, 1'b0, -1);
    lookup_rollback(32'h0000_0100);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_2", hit_cnt, 32'd2);
    check("perf_miss_1", miss_cnt, 32'd1);
`endif

    // Conflict on index 0, then the old line misses again.
    fetch(32'h0000_0204, 0, 1'b0, -1);
    fetch(32'h0000_0104, 0, 1'b0, -1);

    // Fill another index, evict 0x100, then abort a refill of 0x104.
    fetch(32'h0000_0310, 0, 1'b0, -1);
    fetch(32'h0000_0200, 0, 1'b0, -1);
    fetch(32'h0000_0104, 2, 1'b0, -1);
    fetch(32'h0000_0104, 0, 1'b0, -1);
    fetch(32'h0000_0314, 0, 1'b0, -1);

    // Rollback together with the last refill word: line stays invalid.
    fetch(32'h0000_0404, 0, 1'b1, -1);
    fetch(32'h0000_0404, 0, 1'b0, -1);

    // rdy low for 5 cycles mid-refill, then re-fetch of every word.
    fetch(32'h0000_0508, 0, 1'b0, 2);
    for (int w = 0; w < WORDS; w++) fetch(32'h0000_0500 + 32'(4 * w), 0, 1'b0, -1);

    // Last word of a line requested (answer is the final refill word).
    fetch(32'h8000_06FC, 0, 1'b0, 3);

    // Randomized traffic over a small address space to force conflicts.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      int r;
      pc = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      r = $urandom_range(0, 9);
      case (r)
        0:       fetch(pc, $urandom_range(1, 3), 1'b0, -1);
        1:       fetch(pc, 0, 1'b1, -1);
        2:       fetch(pc, 0, 1'b0, $urandom_range(0, 3));
        3:       lookup_rollback(pc);
        default: fetch(pc, 0, 1'b0, -1);
      endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_final", hit_cnt, 32'(m_hit));
    check("perf_miss_final", miss_cnt, 32'(m_miss));
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
